// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// Keeps address/data widths and the busy-mask encoding in one place.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is never a real destination, so it never marks anything busy.
  function automatic logic [XLEN-1:0] rd2mask(input logic [REG_ADDR_W-1:0] rd);
    logic [XLEN-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    mask[0]  = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/wb_mdu_fifo.sv
// Circular buffer holding MDU results until they win the write port.
// Exposes post-update per-entry valid/rd so the parent can register a busy mask.
module wb_mdu_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [REG_ADDR_W-1:0]         wr_rd,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          rd_en,
  output logic [REG_ADDR_W-1:0]         head_rd,
  output logic [XLEN-1:0]               head_data,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              entry_valid_next,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_rd_next
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_reg;
  logic [IDX_W:0]   rd_ptr_reg;
  logic [DEPTH-1:0] valid_reg;
  wb_req_t          mem [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             do_wr;
  logic             do_rd;

  assign wr_idx = wr_ptr_reg[IDX_W-1:0];
  assign rd_idx = rd_ptr_reg[IDX_W-1:0];

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign head_rd   = mem[rd_idx].rd;
  assign head_data = mem[rd_idx].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      valid_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      valid_reg <= entry_valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_idx] <= '{rd: wr_rd, data: wr_data};
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hit_wr;
      logic hit_rd;
      assign hit_wr = do_wr && (wr_idx == IDX_W'(gi));
      assign hit_rd = do_rd && (rd_idx == IDX_W'(gi));
      assign entry_valid_next[gi] = (valid_reg[gi] && !hit_rd) || hit_wr;
      assign entry_rd_next[gi*REG_ADDR_W +: REG_ADDR_W] = hit_wr ? wr_rd : mem[gi].rd;
    end
  endgenerate

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and buffered MDU results,
// forcing a one-cycle pipeline stall when the oldest MDU result starves.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MDU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [XLEN-1:0]       ResultW,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  stall_req,
  output logic [XLEN-1:0]       busy_mask
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                               fifo_empty;
  logic                               fifo_full;
  logic [REG_ADDR_W-1:0]              head_rd;
  logic [XLEN-1:0]                    head_data;
  logic [MDU_FIFO_DEPTH-1:0]          entry_valid_next;
  logic [MDU_FIFO_DEPTH*REG_ADDR_W-1:0] entry_rd_next;

  logic                  rf_we_reg;
  logic [REG_ADDR_W-1:0] rf_addr_reg;
  logic [XLEN-1:0]       rf_wdata_reg;
  logic                  stall_reg;
  logic                  stall_next;
  logic [XLEN-1:0]       busy_reg;
  logic [XLEN-1:0]       busy_next;
  logic [CNT_W-1:0]      starve_cnt_reg;
  logic [CNT_W-1:0]      starve_cnt_next;

  logic pw;
  logic grant_fifo;
  logic fifo_write;

  wb_mdu_fifo #(.DEPTH(MDU_FIFO_DEPTH)) u_fifo (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (mdu_valid),
    .wr_rd            (mdu_rd),
    .wr_data          (mdu_data),
    .rd_en            (grant_fifo),
    .head_rd          (head_rd),
    .head_data        (head_data),
    .empty            (fifo_empty),
    .full             (fifo_full),
    .entry_valid_next (entry_valid_next),
    .entry_rd_next    (entry_rd_next)
  );

  assign mdu_ready = !fifo_full;

  // During the stall cycle the writeback slot is frozen, so the head always wins.
  assign pw         = RegWriteW && (RdW != '0) && !stall_reg;
  assign grant_fifo = !pw && !fifo_empty;
  assign fifo_write = grant_fifo && (head_rd != '0);

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (fifo_empty || grant_fifo) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  assign stall_next = !fifo_empty && !grant_fifo &&
                      (starve_cnt_reg == CNT_W'(STARVE_LIMIT - 1));

  always_comb begin
    busy_next = '0;
    for (int i = 0; i < MDU_FIFO_DEPTH; i++) begin
      if (entry_valid_next[i]) begin
        busy_next = busy_next | rd2mask(entry_rd_next[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg      <= 1'b0;
      rf_addr_reg    <= '0;
      rf_wdata_reg   <= '0;
      stall_reg      <= 1'b0;
      busy_reg       <= '0;
      starve_cnt_reg <= '0;
    end else begin
      rf_we_reg      <= pw || fifo_write;
      stall_reg      <= stall_next;
      busy_reg       <= busy_next;
      starve_cnt_reg <= starve_cnt_next;
      if (pw) begin
        rf_addr_reg  <= RdW;
        rf_wdata_reg <= ResultW;
      end else if (fifo_write) begin
        rf_addr_reg  <= head_rd;
        rf_wdata_reg <= head_data;
      end
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_addr   = rf_addr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign stall_req = stall_reg;
  assign busy_mask = busy_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter: a queue-based reference model predicts each
// cycle's outputs into a scoreboard that an independent monitor drains and compares.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] busy_mask;

  wb_port_arbiter #(.MDU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .busy_mask (busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          we;
    bit          chk_ad;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          stall;
    logic [31:0] busy;
    bit          ready;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t        sq[$];
  ent_t        mq[$];
  int          head_vis;
  int          cyc;
  bit          stall_m;
  bit          hold_pipe;
  bit          h_rw;
  logic [4:0]  h_rd;
  logic [31:0] h_res;
  int          checks;
  int          errors;

  function automatic void chk(input string name, input int c, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL cyc %0d %s: got %h expected %h", c, name, act, req);
    end
  endfunction

  // Reference model: the MDU buffer is a plain queue; a head starves once it has
  // gone ungranted for LIMIT consecutive cycles since it became the head.
  task automatic step(input bit r, input bit rw, input logic [4:0] rd, input logic [31:0] res,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      output bit acc);
    exp_t e;
    ent_t h;
    ent_t n;
    bit   pw;
    bit   popped;
    bit   was_empty;
    bit   nstall;
    @(negedge clk);
    if (hold_pipe && !r) begin
      rw  = h_rw;
      rd  = h_rd;
      res = h_res;
    end
    rst = r; RegWriteW = rw; RdW = rd; ResultW = res;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    e.we = 0; e.chk_ad = 0; e.addr = '0; e.data = '0; e.cyc = cyc + 1;
    acc = 0;
    if (r) begin
      mq.delete();
      stall_m   = 0;
      hold_pipe = 0;
      e.chk_ad  = 1;
    end else begin
      acc       = mv && (mq.size() < DEPTH);
      pw        = rw && (rd != 0) && !stall_m;
      was_empty = (mq.size() == 0);
      popped    = 0;
      nstall    = 0;
      if (pw) begin
        e.we = 1; e.chk_ad = 1; e.addr = rd; e.data = res;
        if (!was_empty && (cyc - head_vis + 1 == LIMIT)) nstall = 1;
      end else if (!was_empty) begin
        h = mq.pop_front();
        popped   = 1;
        e.we     = (h.rd != 0);
        e.chk_ad = e.we;
        e.addr   = h.rd;
        e.data   = h.data;
      end
      if (acc) begin
        n.rd = mrd; n.data = md;
        mq.push_back(n);
      end
      if ((popped || was_empty) && mq.size() > 0) head_vis = cyc + 1;
      // The instruction sitting in writeback during a stall is presented again next cycle.
      hold_pipe = stall_m;
      h_rw = rw; h_rd = rd; h_res = res;
      stall_m = nstall;
    end
    e.stall = stall_m;
    e.busy  = '0;
    foreach (mq[i]) if (mq[i].rd != 0) e.busy[mq[i].rd] = 1'b1;
    e.ready = (mq.size() < DEPTH);
    sq.push_back(e);
    cyc++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("rf_we", e.cyc, {31'b0, rf_we}, {31'b0, e.we});
        if (e.chk_ad) begin
          chk("rf_addr", e.cyc, {27'b0, rf_addr}, {27'b0, e.addr});
          chk("rf_wdata", e.cyc, rf_wdata, e.data);
        end
        chk("stall_req", e.cyc, {31'b0, stall_req}, {31'b0, e.stall});
        chk("busy_mask", e.cyc, busy_mask, e.busy);
        chk("mdu_ready", e.cyc, {31'b0, mdu_ready}, {31'b0, e.ready});
        $display("cyc %0d we=%0b addr=%0d data=%h stall=%0b busy=%h ready=%0b",
                 e.cyc, rf_we, rf_addr, rf_wdata, stall_req, busy_mask, mdu_ready);
      end
    end
  end

  initial begin
    bit acc;
    int k;
    checks = 0; errors = 0; cyc = 0; head_vis = 0;
    stall_m = 0; hold_pipe = 0; h_rw = 0; h_rd = '0; h_res = '0;
    rst = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

    // Reset held while requests are driven.
    repeat (2) step(1, 1, 5'd5, 32'h1, 1, 5'd9, 32'h2, acc);

    // Pipeline only, then x0 from the pipeline.
    step(0, 1, 5'd5, 32'h10, 0, 5'd0, 32'h0, acc);
    step(0, 1, 5'd0, 32'h20, 0, 5'd0, 32'h0, acc);
    repeat (2) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // MDU result into an idle port.
    step(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hABCD, acc);
    repeat (3) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // Starvation under continuous pipeline writes.
    step(0, 1, 5'd10, 32'h100, 1, 5'd3, 32'h3333, acc);
    for (int i = 0; i < 9; i++) step(0, 1, 5'(11 + i), 32'h200 + i, 0, 5'd0, 32'h0, acc);
    repeat (2) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // Fill the buffer: three results offered back to back while writeback is busy.
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      step(0, 1, 5'd20, 32'h400 + i, 1, 5'(11 + k), 32'hD0 + k, acc);
      if (acc) k++;
    end
    repeat (3) step(0, 1, 5'd21, 32'h500, 0, 5'd0, 32'h0, acc);
    repeat (6) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // x0 MDU result is dequeued without a write.
    step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hEEEE, acc);
    repeat (3) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // Reset while two entries are waiting.
    step(0, 1, 5'd4, 32'h600, 1, 5'd12, 32'h612, acc);
    step(0, 1, 5'd4, 32'h601, 1, 5'd13, 32'h613, acc);
    step(1, 1, 5'd4, 32'h602, 0, 5'd0, 32'h0, acc);
    repeat (4) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 70),
           5'($urandom_range(0, 31)),
           $urandom,
           ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 31)),
           $urandom,
           acc);
    end
    repeat (3) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, acc);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
